// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline control slice: control-word bit
// positions, forwarding-select encodings, stage indices and default widths.
package pipe_pkg;

    localparam int CTRL_W_DEF = 10;
    localparam int RA_W_DEF   = 5;
    localparam int CNT_W_DEF  = 16;

    // Control word layout, MSB first: {RegDs, Branch, MRead, MtoR, AOp[2:0], MWrite, ALUsrc, Rw}
    localparam int RW_B     = 0;
    localparam int ALUSRC_B = 1;
    localparam int MWRITE_B = 2;
    localparam int AOP_LSB  = 3;
    localparam int MTOR_B   = 6;
    localparam int MREAD_B  = 7;
    localparam int BRANCH_B = 8;
    localparam int REGDS_B  = 9;

    localparam int ST_EX    = 0;
    localparam int ST_MEM   = 1;
    localparam int ST_WB    = 2;
    localparam int N_STAGES = 3;

    typedef enum logic [1:0] {
        FWD_RF  = 2'b00,
        FWD_WB  = 2'b01,
        FWD_MEM = 2'b10
    } fwd_sel_e;

    // A producer only counts when it is live, writes back, and targets a non-zero register.
    function automatic logic fwd_hit(input logic vld, input logic rw,
                                     input logic dst_nz, input logic addr_eq);
        return vld & rw & dst_nz & addr_eq;
    endfunction

endpackage

// File: rtl/pipe_ctrl_if.sv
// Handshake bundle between the ID-side control path and the pipeline
// controller; the controller uses the slave view.
interface pipe_ctrl_if
    import pipe_pkg::*;
#(
    parameter int CTRL_W = CTRL_W_DEF,
    parameter int RA_W   = RA_W_DEF,
    parameter int CNT_W  = CNT_W_DEF
) ();

    logic              id_valid;
    logic [CTRL_W-1:0] id_ctrl;
    logic [RA_W-1:0]   id_rs;
    logic [RA_W-1:0]   id_rt;
    logic [RA_W-1:0]   id_dst;
    logic              mem_br_taken;

    logic [CTRL_W-1:0] ex_ctrl;
    logic [CTRL_W-1:0] mem_ctrl;
    logic [CTRL_W-1:0] wb_ctrl;
    logic              ex_vld;
    logic              mem_vld;
    logic              wb_vld;
    logic [RA_W-1:0]   wb_dst;
    logic              hold_pc_ifid;
    logic              flush_ifid;
    logic [1:0]        fwd_a;
    logic [1:0]        fwd_b;
    logic [CNT_W-1:0]  stall_cnt;
    logic [CNT_W-1:0]  flush_cnt;

    modport master (
        output id_valid, id_ctrl, id_rs, id_rt, id_dst, mem_br_taken,
        input  ex_ctrl, mem_ctrl, wb_ctrl, ex_vld, mem_vld, wb_vld, wb_dst,
        input  hold_pc_ifid, flush_ifid, fwd_a, fwd_b, stall_cnt, flush_cnt
    );

    modport slave (
        input  id_valid, id_ctrl, id_rs, id_rt, id_dst, mem_br_taken,
        output ex_ctrl, mem_ctrl, wb_ctrl, ex_vld, mem_vld, wb_vld, wb_dst,
        output hold_pc_ifid, flush_ifid, fwd_a, fwd_b, stall_cnt, flush_cnt
    );

endinterface

// File: rtl/pipe_ctrl_stage_reg.sv
// One pipeline stage entry: a plain register with async active-low clear
// and a synchronous bubble that loads an all-zero (invalid) entry.
module pipe_stage_reg #(
    parameter int W = 8
) (
    input  logic         CLK,
    input  logic         RSTn,
    input  logic         bubble,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] data_reg;

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            data_reg <= '0;
        end else if (bubble) begin
            data_reg <= '0;
        end else begin
            data_reg <= d;
        end
    end

    assign q = data_reg;

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline controller: EX/MEM/WB control tracking, load-use stall, taken-branch
// flush, ALU operand forwarding selects and saturating stall/flush counters.
module pipe_ctrl
    import pipe_pkg::*;
#(
    parameter int CTRL_W = CTRL_W_DEF,
    parameter int RA_W   = RA_W_DEF,
    parameter int CNT_W  = CNT_W_DEF
) (
    input  logic       CLK,
    input  logic       RSTn,
    pipe_ctrl_if.slave bus
);

    // Entry layout, MSB first: {vld, ctrl, dst, rs, rt}
    localparam int ENT_W = 1 + CTRL_W + 3 * RA_W;

    logic [ENT_W-1:0]    stage_in  [N_STAGES];
    logic [ENT_W-1:0]    stage_out [N_STAGES];
    logic [N_STAGES-1:0] bubble;

    logic [N_STAGES-1:0] stg_vld;
    logic [CTRL_W-1:0]   stg_ctrl [N_STAGES];
    logic [RA_W-1:0]     stg_dst  [N_STAGES];
    logic [RA_W-1:0]     stg_rs   [N_STAGES];
    logic [RA_W-1:0]     stg_rt   [N_STAGES];

    logic [CTRL_W-1:0]   id_ctrl_masked;
    logic                load_use;
    logic                br_flush;
    logic                stall_eff;

    logic [CNT_W-1:0]    stall_cnt_reg;
    logic [CNT_W-1:0]    stall_cnt_next;
    logic [CNT_W-1:0]    flush_cnt_reg;
    logic [CNT_W-1:0]    flush_cnt_next;

    logic [RA_W-1:0]     ex_src  [2];
    logic [1:0]          mem_hit;
    logic [1:0]          wb_hit;
    fwd_sel_e            fwd_sel [2];
    logic                unused_ok;

    genvar gi;

    generate
        for (gi = 0; gi < N_STAGES; gi++) begin : g_stage
            pipe_stage_reg #(.W(ENT_W)) u_stage (
                .CLK    (CLK),
                .RSTn   (RSTn),
                .bubble (bubble[gi]),
                .d      (stage_in[gi]),
                .q      (stage_out[gi])
            );

            assign stg_vld[gi]  = stage_out[gi][ENT_W-1];
            assign stg_ctrl[gi] = stage_out[gi][ENT_W-2 -: CTRL_W];
            assign stg_dst[gi]  = stage_out[gi][3*RA_W-1 -: RA_W];
            assign stg_rs[gi]   = stage_out[gi][2*RA_W-1 -: RA_W];
            assign stg_rt[gi]   = stage_out[gi][RA_W-1:0];
        end
    endgenerate

    // Masking here keeps every stage's ctrl at zero whenever its vld is zero.
    assign id_ctrl_masked = bus.id_ctrl & {CTRL_W{bus.id_valid}};

    assign load_use = bus.id_valid & stg_vld[ST_EX] & stg_ctrl[ST_EX][MREAD_B]
                    & (|stg_dst[ST_EX])
                    & ((stg_dst[ST_EX] == bus.id_rs) | (stg_dst[ST_EX] == bus.id_rt));

    assign br_flush  = bus.mem_br_taken;
    // A taken branch squashes the stalled instruction anyway, so it overrides the hold.
    assign stall_eff = load_use & ~br_flush;

    always_comb begin
        stage_in[ST_EX]  = {bus.id_valid, id_ctrl_masked, bus.id_dst, bus.id_rs, bus.id_rt};
        stage_in[ST_MEM] = stage_out[ST_EX];
        stage_in[ST_WB]  = stage_out[ST_MEM];

        bubble          = '0;
        bubble[ST_EX]   = load_use | br_flush;
        bubble[ST_MEM]  = br_flush;
    end

    always_comb begin
        stall_cnt_next = stall_cnt_reg;
        flush_cnt_next = flush_cnt_reg;
        if (stall_eff && !(&stall_cnt_reg)) begin
            stall_cnt_next = stall_cnt_reg + CNT_W'(1);
        end
        if (br_flush && !(&flush_cnt_reg)) begin
            flush_cnt_next = flush_cnt_reg + CNT_W'(1);
        end
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            stall_cnt_reg <= '0;
            flush_cnt_reg <= '0;
        end else begin
            stall_cnt_reg <= stall_cnt_next;
            flush_cnt_reg <= flush_cnt_next;
        end
    end

    assign ex_src[0] = stg_rs[ST_EX];
    assign ex_src[1] = stg_rt[ST_EX];

    // Operand 0 is A (rs), operand 1 is B (rt); the younger MEM producer wins over WB.
    generate
        for (gi = 0; gi < 2; gi++) begin : g_fwd
            assign mem_hit[gi] = fwd_hit(stg_vld[ST_MEM], stg_ctrl[ST_MEM][RW_B],
                                         |stg_dst[ST_MEM], stg_dst[ST_MEM] == ex_src[gi]);
            assign wb_hit[gi]  = fwd_hit(stg_vld[ST_WB], stg_ctrl[ST_WB][RW_B],
                                         |stg_dst[ST_WB], stg_dst[ST_WB] == ex_src[gi]);
            assign fwd_sel[gi] = mem_hit[gi] ? FWD_MEM : (wb_hit[gi] ? FWD_WB : FWD_RF);
        end
    endgenerate

    assign bus.fwd_a        = fwd_sel[0];
    assign bus.fwd_b        = fwd_sel[1];
    assign bus.hold_pc_ifid = stall_eff;
    // Gating with RSTn keeps the flush request quiet while the pipe is held in reset.
    assign bus.flush_ifid   = br_flush & RSTn;

    assign bus.ex_vld    = stg_vld[ST_EX];
    assign bus.mem_vld   = stg_vld[ST_MEM];
    assign bus.wb_vld    = stg_vld[ST_WB];
    assign bus.ex_ctrl   = stg_ctrl[ST_EX];
    assign bus.mem_ctrl  = stg_ctrl[ST_MEM];
    assign bus.wb_ctrl   = stg_ctrl[ST_WB];
    assign bus.wb_dst    = stg_dst[ST_WB];
    assign bus.stall_cnt = stall_cnt_reg;
    assign bus.flush_cnt = flush_cnt_reg;

    // Source addresses ride along to MEM/WB for debug visibility only.
    assign unused_ok = ^{stg_rs[ST_MEM], stg_rt[ST_MEM], stg_rs[ST_WB], stg_rt[ST_WB]};

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: directed vector table, randomized traffic
// against a behavioural pipeline model, counter saturation and async reset.
module tb_pipe_ctrl;
    import pipe_pkg::*;

    localparam int CW       = 10;
    localparam int AW       = 5;
    // A narrow counter lets saturation be reached in a few hundred cycles.
    localparam int TB_CNT_W = 6;
    localparam int SAT      = (1 << TB_CNT_W) - 1;

    localparam logic [9:0] C_ALU = 10'h211;
    localparam logic [9:0] C_LW  = 10'h0C3;
    localparam logic [9:0] C_BEQ = 10'h108;
    localparam logic [9:0] C_SW  = 10'h006;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    pipe_ctrl_if #(.CTRL_W(CW), .RA_W(AW), .CNT_W(TB_CNT_W)) bus ();

    pipe_ctrl #(.CTRL_W(CW), .RA_W(AW), .CNT_W(TB_CNT_W)) dut (
        .CLK  (clk),
        .RSTn (rst_n),
        .bus  (bus)
    );

    typedef struct {
        bit       vld;
        bit [9:0] ctrl;
        bit [4:0] dst;
        bit [4:0] rs;
        bit [4:0] rt;
    } ins_t;

    typedef struct {
        bit       v;
        bit [9:0] ctrl;
        bit [4:0] rs;
        bit [4:0] rt;
        bit [4:0] dst;
        bit       br;
        bit       e_hold;
        bit       e_flush;
        bit [1:0] e_fa;
        bit [1:0] e_fb;
        bit       e_ex;
        bit       e_mem;
        bit       e_wb;
        int       e_sc;
        int       e_fc;
    } vec_t;

    ins_t m_ex, m_mem, m_wb;
    int   m_stall, m_flush;
    int   n_tests = 0;
    int   n_fail  = 0;
    vec_t tbl [19];

    task automatic chk(input string tag, input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s/%s: actual=%0h required=%0h", tag, name, act, exp);
        end
    endtask

    function automatic vec_t mk(input bit v, input bit [9:0] ctrl, input bit [4:0] rs, input bit [4:0] rt,
                                input bit [4:0] dst, input bit br, input bit h, input bit f,
                                input bit [1:0] fa, input bit [1:0] fb, input bit ex, input bit mem,
                                input bit wb, input int sc, input int fc);
        vec_t t;
        t.v = v; t.ctrl = ctrl; t.rs = rs; t.rt = rt; t.dst = dst; t.br = br;
        t.e_hold = h; t.e_flush = f; t.e_fa = fa; t.e_fb = fb;
        t.e_ex = ex; t.e_mem = mem; t.e_wb = wb; t.e_sc = sc; t.e_fc = fc;
        return t;
    endfunction

    function automatic vec_t ins(input bit v, input bit [9:0] ctrl, input bit [4:0] rs,
                                 input bit [4:0] rt, input bit [4:0] dst, input bit br);
        return mk(v, ctrl, rs, rt, dst, br, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endfunction

    // Who would an EX operand read? The youngest live writer of that non-zero register.
    function automatic bit [1:0] ref_fwd(input bit [4:0] src);
        if (src != 0 && m_mem.vld && m_mem.ctrl[RW_B] && m_mem.dst == src) return 2'b10;
        if (src != 0 && m_wb.vld && m_wb.ctrl[RW_B] && m_wb.dst == src) return 2'b01;
        return 2'b00;
    endfunction

    task automatic model_reset();
        m_ex = '{default: '0};
        m_mem = '{default: '0};
        m_wb = '{default: '0};
        m_stall = 0;
        m_flush = 0;
    endtask

    task automatic run_cycle(input vec_t t, input bit use_tbl, input string tag);
        bit   lu, hold;
        ins_t nx_ex, nx_mem, nx_wb, empty, id_ins;
        empty = '{default: '0};
        bus.id_valid = t.v; bus.id_ctrl = t.ctrl; bus.id_rs = t.rs;
        bus.id_rt = t.rt; bus.id_dst = t.dst; bus.mem_br_taken = t.br;
        @(negedge clk);
        lu = t.v && m_ex.vld && m_ex.ctrl[MREAD_B] && m_ex.dst != 0 && (m_ex.dst == t.rs || m_ex.dst == t.rt);
        hold = lu && !t.br;
        chk(tag, "hold_pc_ifid", 32'(bus.hold_pc_ifid), 32'(hold));
        chk(tag, "flush_ifid", 32'(bus.flush_ifid), 32'(t.br));
        if (m_ex.vld) begin
            chk(tag, "fwd_a", 32'(bus.fwd_a), 32'(ref_fwd(m_ex.rs)));
            chk(tag, "fwd_b", 32'(bus.fwd_b), 32'(ref_fwd(m_ex.rt)));
        end
        chk(tag, "ex_vld", 32'(bus.ex_vld), 32'(m_ex.vld));
        chk(tag, "mem_vld", 32'(bus.mem_vld), 32'(m_mem.vld));
        chk(tag, "wb_vld", 32'(bus.wb_vld), 32'(m_wb.vld));
        chk(tag, "ex_ctrl", 32'(bus.ex_ctrl), 32'(m_ex.vld ? m_ex.ctrl : 10'd0));
        chk(tag, "mem_ctrl", 32'(bus.mem_ctrl), 32'(m_mem.vld ? m_mem.ctrl : 10'd0));
        chk(tag, "wb_ctrl", 32'(bus.wb_ctrl), 32'(m_wb.vld ? m_wb.ctrl : 10'd0));
        if (m_wb.vld) chk(tag, "wb_dst", 32'(bus.wb_dst), 32'(m_wb.dst));
        chk(tag, "stall_cnt", 32'(bus.stall_cnt), 32'(m_stall));
        chk(tag, "flush_cnt", 32'(bus.flush_cnt), 32'(m_flush));
        if (use_tbl) begin
            chk(tag, "tbl_hold", 32'(bus.hold_pc_ifid), 32'(t.e_hold));
            chk(tag, "tbl_flush", 32'(bus.flush_ifid), 32'(t.e_flush));
            if (t.e_ex) begin
                chk(tag, "tbl_fwd_a", 32'(bus.fwd_a), 32'(t.e_fa));
                chk(tag, "tbl_fwd_b", 32'(bus.fwd_b), 32'(t.e_fb));
            end
            chk(tag, "tbl_ex_vld", 32'(bus.ex_vld), 32'(t.e_ex));
            chk(tag, "tbl_mem_vld", 32'(bus.mem_vld), 32'(t.e_mem));
            chk(tag, "tbl_wb_vld", 32'(bus.wb_vld), 32'(t.e_wb));
            chk(tag, "tbl_stall_cnt", 32'(bus.stall_cnt), 32'(t.e_sc));
            chk(tag, "tbl_flush_cnt", 32'(bus.flush_cnt), 32'(t.e_fc));
        end
        id_ins = '{vld: t.v, ctrl: t.ctrl, dst: t.dst, rs: t.rs, rt: t.rt};
        nx_wb  = m_mem;
        nx_mem = t.br ? empty : m_ex;
        nx_ex  = (t.br || lu) ? empty : id_ins;
        @(posedge clk);
        #1;
        m_ex = nx_ex; m_mem = nx_mem; m_wb = nx_wb;
        if (hold && m_stall < SAT) m_stall++;
        if (t.br && m_flush < SAT) m_flush++;
    endtask

    task automatic chk_all_clear(input string tag);
        chk(tag, "ex_vld", 32'(bus.ex_vld), 0);
        chk(tag, "mem_vld", 32'(bus.mem_vld), 0);
        chk(tag, "wb_vld", 32'(bus.wb_vld), 0);
        chk(tag, "ex_ctrl", 32'(bus.ex_ctrl), 0);
        chk(tag, "mem_ctrl", 32'(bus.mem_ctrl), 0);
        chk(tag, "wb_ctrl", 32'(bus.wb_ctrl), 0);
        chk(tag, "wb_dst", 32'(bus.wb_dst), 0);
        chk(tag, "fwd_a", 32'(bus.fwd_a), 0);
        chk(tag, "fwd_b", 32'(bus.fwd_b), 0);
        chk(tag, "hold_pc_ifid", 32'(bus.hold_pc_ifid), 0);
        chk(tag, "flush_ifid", 32'(bus.flush_ifid), 0);
        chk(tag, "stall_cnt", 32'(bus.stall_cnt), 0);
        chk(tag, "flush_cnt", 32'(bus.flush_cnt), 0);
    endtask

    function automatic vec_t rnd_vec();
        vec_t t;
        t = ins(0, 0, 0, 0, 0, 0);
        t.v = ($urandom_range(0, 9) < 8);
        case ($urandom_range(0, 4))
            0:       t.ctrl = C_ALU;
            1:       t.ctrl = C_LW;
            2:       t.ctrl = C_BEQ;
            3:       t.ctrl = C_SW;
            default: t.ctrl = 10'($urandom);
        endcase
        t.rs  = 5'($urandom_range(0, 7));
        t.rt  = 5'($urandom_range(0, 7));
        t.dst = 5'($urandom_range(0, 7));
        t.br  = ($urandom_range(0, 9) == 0);
        return t;
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t v_lw, v_use;

        //            v  ctrl   rs rt dst br | hold fl fa fb ex mem wb sc fc
        tbl[0]  = mk(1, C_ALU, 1, 2, 3,  0,   0,  0, 0, 0, 0, 0,  0, 0, 0);
        tbl[1]  = mk(1, C_ALU, 3, 1, 4,  0,   0,  0, 0, 0, 1, 0,  0, 0, 0);
        tbl[2]  = mk(0, 10'd0, 0, 0, 0,  0,   0,  0, 2, 0, 1, 1,  0, 0, 0);
        tbl[3]  = mk(1, C_LW,  1, 5, 5,  0,   0,  0, 0, 0, 0, 1,  1, 0, 0);
        tbl[4]  = mk(1, C_ALU, 5, 2, 6,  0,   1,  0, 0, 0, 1, 0,  1, 0, 0);
        tbl[5]  = mk(1, C_ALU, 5, 2, 6,  0,   0,  0, 0, 0, 0, 1,  0, 1, 0);
        tbl[6]  = mk(0, 10'd0, 0, 0, 0,  0,   0,  0, 1, 0, 1, 0,  1, 1, 0);
        tbl[7]  = mk(1, C_BEQ, 1, 2, 0,  0,   0,  0, 0, 0, 0, 1,  0, 1, 0);
        tbl[8]  = mk(1, C_ALU, 1, 2, 7,  0,   0,  0, 0, 0, 1, 0,  1, 1, 0);
        tbl[9]  = mk(1, C_ALU, 7, 1, 8,  1,   0,  1, 0, 0, 1, 1,  0, 1, 0);
        tbl[10] = mk(0, 10'd0, 0, 0, 0,  0,   0,  0, 0, 0, 0, 0,  1, 1, 1);
        tbl[11] = mk(1, C_LW,  1, 5, 5,  0,   0,  0, 0, 0, 0, 0,  0, 1, 1);
        tbl[12] = mk(1, C_ALU, 5, 5, 9,  1,   0,  1, 0, 0, 1, 0,  0, 1, 1);
        tbl[13] = mk(0, 10'd0, 0, 0, 0,  0,   0,  0, 0, 0, 0, 0,  0, 1, 2);
        tbl[14] = mk(1, C_ALU, 1, 2, 0,  0,   0,  0, 0, 0, 0, 0,  0, 1, 2);
        tbl[15] = mk(1, C_ALU, 0, 0, 10, 0,   0,  0, 0, 0, 1, 0,  0, 1, 2);
        tbl[16] = mk(1, C_LW,  1, 0, 0,  0,   0,  0, 0, 0, 1, 1,  0, 1, 2);
        tbl[17] = mk(1, C_ALU, 0, 0, 11, 0,   0,  0, 0, 0, 1, 1,  1, 1, 2);
        tbl[18] = mk(0, 10'd0, 0, 0, 0,  0,   0,  0, 0, 0, 1, 1,  1, 1, 2);

        bus.id_valid = 0; bus.id_ctrl = '0; bus.id_rs = '0;
        bus.id_rt = '0; bus.id_dst = '0; bus.mem_br_taken = 0;
        model_reset();

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_all_clear("reset");
        @(posedge clk);
        #1 rst_n = 1'b1;

        for (int i = 0; i < 19; i++) run_cycle(tbl[i], 1'b1, $sformatf("tbl%0d", i));

        for (int i = 0; i < 400; i++) run_cycle(rnd_vec(), 1'b0, $sformatf("rnd%0d", i));

        v_lw  = ins(1, C_LW,  1, 5, 5, 0);
        v_use = ins(1, C_ALU, 5, 2, 6, 0);
        for (int k = 0; k < 2 * (SAT + 5); k++) run_cycle(((k % 2) == 0) ? v_lw : v_use, 1'b0, "sat");
        chk("sat", "stall_cnt_saturated", 32'(bus.stall_cnt), SAT);

        // Mid-stall reset: the clear must be visible before any clock edge.
        run_cycle(v_lw, 1'b0, "pre_rst");
        bus.id_valid = 1; bus.id_ctrl = C_ALU; bus.id_rs = 5;
        bus.id_rt = 2; bus.id_dst = 6; bus.mem_br_taken = 0;
        #1 chk("pre_rst", "hold_pc_ifid", 32'(bus.hold_pc_ifid), 1);
        #1 rst_n = 1'b0;
        #1 chk_all_clear("async_rst");
        model_reset();
        @(posedge clk);
        #1 rst_n = 1'b1;

        run_cycle(ins(1, C_ALU, 1, 2, 7, 0), 1'b0, "post_rst0");
        run_cycle(ins(1, C_ALU, 7, 7, 8, 0), 1'b0, "post_rst1");
        run_cycle(ins(0, 10'd0, 0, 0, 0, 0), 1'b0, "post_rst2");
        run_cycle(ins(0, 10'd0, 0, 0, 0, 0), 1'b0, "post_rst3");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 Parameter CTRL_W, default 10: width of the decoded control word {RegDs, Branch, MRead, MtoR, AOp[2:0], MWrite, ALUsrc, Rw}.
REQ-002 Parameter RA_W, default 5: register-address width.
REQ-003 Parameter CNT_W, default 16: width of the performance counters.
REQ-004 The block SHALL use one clock and an asynchronous, active-low reset, named CLK and RSTn; no other clock or reset SHALL exist.
REQ-005 CLK  in  1  rising-edge clock for all state.
REQ-006 RSTn  in  1  asynchronous active-low reset.
REQ-007 id_valid  in  1  ID stage holds a real instruction.
REQ-008 id_ctrl  in  CTRL_W  control word from the control unit for the ID instruction.
REQ-009 id_rs, id_rt  in  RA_W each  ID source register addresses.
REQ-010 id_dst  in  RA_W  ID destination, already resolved by RegDs.
REQ-011 mem_br_taken  in  1  MEM-stage Branch AND registered zero flag.
REQ-012 ex_ctrl, mem_ctrl, wb_ctrl  out  CTRL_W each  control word per stage, forced to 0 when that stage is invalid.
REQ-013 ex_vld, mem_vld, wb_vld  out  1 each  stage-valid flags.
REQ-014 wb_dst  out  RA_W  write-back register address.
REQ-015 hold_pc_ifid  out  1  freeze PC and the IF/ID register.
REQ-016 flush_ifid  out  1  clear the IF/ID register on the next edge.
REQ-017 fwd_a, fwd_b  out  2 each  ALU operand select: 00 register file, 10 MEM-stage ALU result, 01 WB-stage value.
REQ-018 stall_cnt, flush_cnt  out  CNT_W each  saturating event counters.

Function
REQ-019 Three registered stage entries (EX, MEM, WB) SHALL each hold {vld, ctrl, dst, rs, rt}; all entries advance every clock edge.
REQ-020 Load-use condition: load_use = id_valid AND ex_vld AND ex MRead AND ex_dst != 0 AND (ex_dst == id_rs OR ex_dst == id_rt).
REQ-021 On load_use, hold_pc_ifid SHALL be 1 combinationally, and the EX entry SHALL receive a bubble (vld=0, ctrl=0) on the next edge.
REQ-022 On mem_br_taken, flush_ifid SHALL be 1, and the EX and MEM entries SHALL receive bubbles on the next edge; the WB entry loads normally from MEM.
REQ-023 When mem_br_taken and load_use coincide, flush SHALL win: hold_pc_ifid=0, and only flush_cnt increments.
REQ-024 Without stall or flush, the EX entry SHALL load {id_valid, id_ctrl, id_dst, id_rs, id_rt}; the ID-to-WB latency is 3 edges.
REQ-025 fwd_a (fwd_b) SHALL be 10 if mem_vld AND mem Rw AND mem_dst != 0 AND mem_dst == ex_rs (ex_rt).
REQ-026 Otherwise fwd_a (fwd_b) SHALL be 01 if the same test passes against the WB entry, else 00; MEM priority is over WB.
REQ-027 Register 0 SHALL never be a forwarding or load-use match.
REQ-028 stall_cnt SHALL increment on each edge where the stall is effective; flush_cnt on each edge with mem_br_taken.
REQ-029 Both counters SHALL saturate at all-ones and never wrap.
REQ-030 All outputs other than fwd_*, hold_pc_ifid and flush_ifid SHALL be registered.

Reset
REQ-031 While RSTn=0, asynchronously: every vld=0, ctrl=0, dst/rs/rt=0, and counters=0.
REQ-032 Consequently, during reset fwd_a=fwd_b=00, hold_pc_ifid=0 and flush_ifid=0.
REQ-033 Reset asserted mid-stall or mid-flush SHALL discard all in-flight entries; the first edge after release loads ID normally.

Structure
REQ-034 A shared package pipe_pkg SHALL hold the control-word bit indices (RW_B, MTOR_B, MREAD_B, MWRITE_B, BRANCH_B, AOP_LSB), the FWD_RF/FWD_MEM/FWD_WB encodings, and the default widths.
REQ-035 One sub-module, pipe_stage_reg, SHALL be instantiated per stage: a parametrised register with async active-low reset and a synchronous bubble input.
REQ-036 Hazard and forwarding logic SHALL stay in pipe_ctrl.

Verification
REQ-037 Back-to-back ALU ops: add r3 in EX-1, then sub using r3 -> fwd_a=10 in the dependent EX cycle; no stall.
REQ-038 lw r5 followed by add using r5 -> one cycle with hold_pc_ifid=1, a bubble in EX, then fwd=01, stall_cnt=1.
REQ-039 mem_br_taken=1 for one cycle -> flush_ifid=1, next ex_vld=mem_vld=0, wb_vld follows the former MEM, flush_cnt=1.
REQ-040 lw r5 load-use in the same cycle as mem_br_taken -> hold_pc_ifid=0, flush_ifid=1, stall_cnt unchanged.
REQ-041 Destination r0 with Rw=1, consumer reads r0 -> fwd=00, no stall.
REQ-042 Force stall_cnt to 0xFFFF via repeated load-use hazards -> it stays at 0xFFFF; RSTn pulse mid-stream -> all vld=0 and counters=0 immediately, without waiting for CLK.
